// File: rtl/mc_frame_arbiter.sv
// mc_frame_arbiter: grants the memory array to one of refresh, write frame or
// read frame at a time, presents the latched frame to the array sequencer and
// waits for the array's completion pulse before arbitrating again.
// Reads win over writes, except that after RD_RUN_MAX consecutive read grants
// with a write pending, the write is forced through.
module mc_frame_arbiter #(
  parameter int FRAME_W    = 97,
  parameter int RD_RUN_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               axi2arb_wframe_valid,
  output logic               axi2arb_wframe_ready,
  input  logic [FRAME_W-1:0] axi2arb_wframe_data,
  input  logic               axi2arb_rframe_valid,
  output logic               axi2arb_rframe_ready,
  input  logic [FRAME_W-1:0] axi2arb_rframe_data,
  input  logic               refresh_req,
  output logic               refresh_ack,
  output logic               arb2array_valid,
  input  logic               arb2array_ready,
  output logic [1:0]         arb2array_type,
  output logic [FRAME_W-1:0] arb2array_data,
  input  logic               array_done,
  output logic               arb_busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam logic [1:0] T_RD = 2'b00;
  localparam logic [1:0] T_WR = 2'b01;
  localparam logic [1:0] T_RF = 2'b10;
  localparam logic [3:0] RUN_MAX = 4'(RD_RUN_MAX);

  state_t               r_state;
  state_t               w_next;
  logic [3:0]           r_rd_run;
  logic [1:0]           r_type;
  logic [FRAME_W-1:0]   r_data;
  logic                 w_idle;
  logic                 w_gnt_rf;
  logic                 w_gnt_wr;
  logic                 w_gnt_rd;

  // Grants are only possible in IDLE; reset masks them so the readies are
  // already low during the reset cycle itself.
  assign w_idle = (r_state == S_IDLE) && !rst;

  // Winner selection: refresh, then a write that is starved or unopposed,
  // then a read.
  always_comb begin
    w_gnt_rf = w_idle && refresh_req;
    w_gnt_wr = w_idle && !refresh_req && axi2arb_wframe_valid &&
               ((r_rd_run == RUN_MAX) || !axi2arb_rframe_valid);
    w_gnt_rd = w_idle && !refresh_req && axi2arb_rframe_valid && !w_gnt_wr;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_next               = r_state;
    axi2arb_wframe_ready = 1'b0;
    axi2arb_rframe_ready = 1'b0;
    arb2array_valid      = 1'b0;
    refresh_ack          = 1'b0;
    arb_busy             = 1'b0;
    case (r_state)
      S_IDLE: begin
        axi2arb_wframe_ready = w_gnt_wr;
        axi2arb_rframe_ready = w_gnt_rd;
        if (w_gnt_rf || w_gnt_wr || w_gnt_rd) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        arb_busy        = 1'b1;
        arb2array_valid = 1'b1;
        if (arb2array_ready) begin
          refresh_ack = (r_type == T_RF);
          w_next      = S_WAIT;
        end
      end
      S_WAIT: begin
        arb_busy = 1'b1;
        if (array_done) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Latch the winner's type and payload on the accepting edge; refresh
  // frames carry an all-zero payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_type <= T_RD;
      r_data <= '0;
    end else if (w_gnt_rf) begin
      r_type <= T_RF;
      r_data <= '0;
    end else if (w_gnt_wr) begin
      r_type <= T_WR;
      r_data <= axi2arb_wframe_data;
    end else if (w_gnt_rd) begin
      r_type <= T_RD;
      r_data <= axi2arb_rframe_data;
    end
  end

  // Consecutive-read counter used to bound write starvation; refresh grants
  // leave it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_run <= '0;
    end else if (w_gnt_wr) begin
      r_rd_run <= '0;
    end else if (w_gnt_rd) begin
      if (!axi2arb_wframe_valid)    r_rd_run <= '0;
      else if (r_rd_run != RUN_MAX) r_rd_run <= r_rd_run + 4'd1;
    end
  end

  assign arb2array_type = r_type;
  assign arb2array_data = r_data;

endmodule

// File: tb/tb_mc_frame_arbiter.sv
// Bench for mc_frame_arbiter: directed scenarios plus a randomized run
// checked against a priority/starvation model of the arbiter.
module tb_mc_frame_arbiter;

  localparam int FW      = 97;
  localparam int RUN_MAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          axi2arb_wframe_valid, axi2arb_wframe_ready;
  logic [FW-1:0] axi2arb_wframe_data;
  logic          axi2arb_rframe_valid, axi2arb_rframe_ready;
  logic [FW-1:0] axi2arb_rframe_data;
  logic          refresh_req, refresh_ack;
  logic          arb2array_valid, arb2array_ready;
  logic [1:0]    arb2array_type;
  logic [FW-1:0] arb2array_data;
  logic          array_done, arb_busy;

  int n_tests = 0;
  int n_fail  = 0;
  int m_run   = 0;   // model consecutive-read count
  bit keep_r  = 0;   // source presents a fresh frame right after an accept
  bit keep_w  = 0;

  typedef struct {
    logic          rr, wr, valid, rr_after, wr_after;
    logic [1:0]    typ;
    logic [FW-1:0] data;
    int            busy, acks;
    logic          stable, glitch, idle_after;
  } grant_t;

  mc_frame_arbiter #(.FRAME_W(FW), .RD_RUN_MAX(RUN_MAX)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .axi2arb_wframe_valid (axi2arb_wframe_valid),
    .axi2arb_wframe_ready (axi2arb_wframe_ready),
    .axi2arb_wframe_data  (axi2arb_wframe_data),
    .axi2arb_rframe_valid (axi2arb_rframe_valid),
    .axi2arb_rframe_ready (axi2arb_rframe_ready),
    .axi2arb_rframe_data  (axi2arb_rframe_data),
    .refresh_req          (refresh_req),
    .refresh_ack          (refresh_ack),
    .arb2array_valid      (arb2array_valid),
    .arb2array_ready      (arb2array_ready),
    .arb2array_type       (arb2array_type),
    .arb2array_data       (arb2array_data),
    .array_done           (array_done),
    .arb_busy             (arb_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [FW-1:0] rand_frame();
    logic [127:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    return t[FW-1:0];
  endfunction

  // Runs one full grant from an IDLE sample point: ISSUE with rdy_dly stalled
  // cycles, then WAIT_DONE with done on its (done_dly+1)th cycle. Returns what
  // was observed; ends in the next IDLE cycle's sample window.
  task automatic run_grant(input int rdy_dly, input int done_dly, input bit stray,
                           output grant_t g);
    g.rr = axi2arb_rframe_ready; g.wr = axi2arb_wframe_ready;
    g.valid = 0; g.typ = 0; g.data = '0; g.busy = 0; g.acks = 0;
    g.stable = 1; g.glitch = 0; g.idle_after = 0; g.rr_after = 0; g.wr_after = 0;
    for (int i = 0; i <= rdy_dly; i++) begin
      @(negedge clk);
      if (i == 0) begin
        if (g.rr) begin
          if (keep_r) axi2arb_rframe_data = rand_frame(); else axi2arb_rframe_valid = 0;
        end
        if (g.wr) begin
          if (keep_w) axi2arb_wframe_data = rand_frame(); else axi2arb_wframe_valid = 0;
        end
      end
      arb2array_ready = (i == rdy_dly);
      array_done      = stray;
      #1;
      if (i == 0) begin
        g.valid = arb2array_valid; g.typ = arb2array_type; g.data = arb2array_data;
      end else if (arb2array_valid !== g.valid || arb2array_type !== g.typ ||
                   arb2array_data !== g.data) begin
        g.stable = 0;
      end
      if (axi2arb_rframe_ready || axi2arb_wframe_ready) g.glitch = 1;
      g.busy += int'(arb_busy);
      g.acks += int'(refresh_ack);
    end
    for (int j = 0; j <= done_dly; j++) begin
      @(negedge clk);
      arb2array_ready = 0;
      array_done      = (j == done_dly);
      if (j == 0 && g.acks != 0) refresh_req = 0;
      #1;
      if (axi2arb_rframe_ready || axi2arb_wframe_ready) g.glitch = 1;
      g.busy += int'(arb_busy);
      g.acks += int'(refresh_ack);
    end
    @(negedge clk);
    array_done = 0;
    #1;
    g.idle_after = !arb_busy;
    g.rr_after   = axi2arb_rframe_ready;
    g.wr_after   = axi2arb_wframe_ready;
  endtask

  task automatic test_reset();
    rst = 1; refresh_req = 0; arb2array_ready = 0; array_done = 0;
    axi2arb_rframe_valid = 0; axi2arb_wframe_valid = 0;
    axi2arb_rframe_data = '0; axi2arb_wframe_data = '0;
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if ({arb2array_valid, refresh_ack, arb_busy, axi2arb_rframe_ready,
         axi2arb_wframe_ready, arb2array_type} !== 7'd0 || arb2array_data !== '0) begin
      n_fail++;
      $display("FAIL reset_outs: got v=%b ack=%b busy=%b type=%b data=%h, expected all 0",
               arb2array_valid, refresh_ack, arb_busy, arb2array_type, arb2array_data);
    end
    @(negedge clk); rst = 0;
    // start a read, then reset while it is in WAIT_DONE
    axi2arb_rframe_valid = 1; axi2arb_rframe_data = rand_frame();
    axi2arb_wframe_valid = 1; axi2arb_wframe_data = rand_frame();
    @(negedge clk); arb2array_ready = 1; axi2arb_rframe_data = rand_frame();
    @(negedge clk); arb2array_ready = 0;
    #1;
    n_tests++;
    if (arb_busy !== 1'b1) begin
      n_fail++; $display("FAIL reset_pre_busy: got %b expected 1", arb_busy);
    end
    #1 rst = 1;
    #1;
    n_tests++;
    if ({arb2array_valid, refresh_ack, arb_busy, axi2arb_rframe_ready,
         axi2arb_wframe_ready, arb2array_type} !== 7'd0 || arb2array_data !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_wait: got v=%b ack=%b busy=%b rr=%b wr=%b type=%b data=%h, expected all 0",
               arb2array_valid, refresh_ack, arb_busy, axi2arb_rframe_ready,
               axi2arb_wframe_ready, arb2array_type, arb2array_data);
    end
    @(negedge clk); rst = 0;
    #1;
    n_tests++;
    if (arb_busy !== 1'b0 || axi2arb_rframe_ready !== 1'b1 || axi2arb_wframe_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle: got busy=%b rr=%b wr=%b expected 0 1 0",
               arb_busy, axi2arb_rframe_ready, axi2arb_wframe_ready);
    end
    axi2arb_rframe_valid = 0; axi2arb_wframe_valid = 0;
    m_run = 0;
  endtask

  task automatic test_lone_read();
    grant_t g;
    keep_r = 0; keep_w = 0;
    axi2arb_rframe_data = FW'(32'h1234); axi2arb_rframe_valid = 1;
    #1;
    run_grant(0, 5, 0, g);
    m_run = 0;
    n_tests++;
    if (g.rr !== 1 || g.wr !== 0 || g.glitch !== 0 || g.rr_after !== 0) begin
      n_fail++;
      $display("FAIL lone_read_ready: got rr=%b wr=%b glitch=%b rr_after=%b expected 1 0 0 0",
               g.rr, g.wr, g.glitch, g.rr_after);
    end
    n_tests++;
    if (g.valid !== 1 || g.typ !== 2'b00 || g.data !== FW'(32'h1234)) begin
      n_fail++;
      $display("FAIL lone_read_frame: got v=%b type=%b data=%h expected 1 00 1234",
               g.valid, g.typ, g.data);
    end
    n_tests++;
    if (g.busy != 7 || g.idle_after !== 1) begin
      n_fail++;
      $display("FAIL lone_read_busy: got %0d cycles idle_after=%b expected 7 1", g.busy, g.idle_after);
    end
  endtask

  task automatic test_starvation();
    grant_t g;
    logic [FW-1:0] er, ew;
    keep_r = 1; keep_w = 1;
    axi2arb_rframe_valid = 1; axi2arb_rframe_data = rand_frame();
    axi2arb_wframe_valid = 1; axi2arb_wframe_data = rand_frame();
    #1;
    for (int i = 0; i < 10; i++) begin
      bit exp_w;
      exp_w = (i % 5 == 4);
      er = axi2arb_rframe_data; ew = axi2arb_wframe_data;
      run_grant(0, 0, 0, g);
      n_tests++;
      if (g.wr !== exp_w || g.rr !== !exp_w || g.typ !== {1'b0, exp_w} ||
          g.data !== (exp_w ? ew : er)) begin
        n_fail++;
        $display("FAIL starve_order[%0d]: got rr=%b wr=%b type=%b expected rr=%b wr=%b",
                 i, g.rr, g.wr, g.typ, !exp_w, exp_w);
      end
    end
    m_run = 0;
  endtask

  task automatic test_refresh();
    grant_t g;
    string  got;
    keep_r = 1; keep_w = 1;
    axi2arb_rframe_valid = 1; axi2arb_wframe_valid = 1;
    #1;
    run_grant(0, 1, 0, g);
    run_grant(0, 1, 0, g);   // two reads: run count now 2
    refresh_req = 1;
    #1;
    run_grant(1, 2, 0, g);
    n_tests++;
    if (g.typ !== 2'b10 || g.data !== '0 || g.rr !== 0 || g.wr !== 0 || g.acks != 1) begin
      n_fail++;
      $display("FAIL refresh_first: got type=%b data=%h rr=%b wr=%b acks=%0d expected 10 0 0 0 1",
               g.typ, g.data, g.rr, g.wr, g.acks);
    end
    got = "";
    for (int i = 0; i < 3; i++) begin
      run_grant(0, 0, 0, g);
      got = {got, g.wr ? "W" : (g.rr ? "R" : "-")};
    end
    n_tests++;
    if (got != "RRW") begin
      n_fail++; $display("FAIL refresh_run_kept: got %s expected RRW", got);
    end
    keep_r = 0; keep_w = 0;
    axi2arb_rframe_valid = 0; axi2arb_wframe_valid = 0;
    m_run = 0;
  endtask

  task automatic test_backpressure();
    grant_t g;
    logic [FW-1:0] ew;
    axi2arb_wframe_valid = 1; axi2arb_wframe_data = rand_frame(); ew = axi2arb_wframe_data;
    #1;
    run_grant(6, 1, 0, g);
    m_run = 0;
    n_tests++;
    if (g.stable !== 1 || g.valid !== 1 || g.typ !== 2'b01 || g.data !== ew) begin
      n_fail++;
      $display("FAIL backpressure_hold: got stable=%b v=%b type=%b data=%h expected 1 1 01 %h",
               g.stable, g.valid, g.typ, g.data, ew);
    end
    n_tests++;
    if (g.glitch !== 0 || g.wr !== 1 || g.busy != 9) begin
      n_fail++;
      $display("FAIL backpressure_ready: got glitch=%b wr=%b busy=%0d expected 0 1 9",
               g.glitch, g.wr, g.busy);
    end
  endtask

  task automatic test_stray_done();
    grant_t g;
    logic [FW-1:0] er;
    array_done = 1;
    #1;
    @(negedge clk); array_done = 0;
    #1;
    n_tests++;
    if (arb_busy !== 0) begin
      n_fail++; $display("FAIL stray_idle: got busy=%b expected 0", arb_busy);
    end
    axi2arb_rframe_valid = 1; axi2arb_rframe_data = rand_frame(); er = axi2arb_rframe_data;
    array_done = 1;
    #1;
    run_grant(2, 3, 1, g);
    m_run = 0;
    n_tests++;
    if (g.busy != 7 || g.idle_after !== 1 || g.typ !== 2'b00 || g.data !== er) begin
      n_fail++;
      $display("FAIL stray_issue: got busy=%0d idle_after=%b type=%b expected 7 1 00",
               g.busy, g.idle_after, g.typ);
    end
  endtask

  task automatic test_random();
    grant_t g;
    logic [1:0]    et;
    logic [FW-1:0] ed;
    bit            err, ewr;
    int            rd, dd;
    keep_r = 0; keep_w = 0;
    for (int it = 0; it < 40; it++) begin
      if (!axi2arb_rframe_valid && $urandom_range(1, 0) == 1) begin
        axi2arb_rframe_valid = 1; axi2arb_rframe_data = rand_frame();
      end
      if (!axi2arb_wframe_valid && $urandom_range(1, 0) == 1) begin
        axi2arb_wframe_valid = 1; axi2arb_wframe_data = rand_frame();
      end
      if (!refresh_req && $urandom_range(4, 0) == 0) refresh_req = 1;
      if (!axi2arb_rframe_valid && !axi2arb_wframe_valid && !refresh_req) begin
        axi2arb_rframe_valid = 1; axi2arb_rframe_data = rand_frame();
      end
      #1;
      err = 0; ewr = 0;
      if (refresh_req) begin
        et = 2'b10; ed = '0;
      end else if (axi2arb_wframe_valid && (m_run == RUN_MAX || !axi2arb_rframe_valid)) begin
        et = 2'b01; ed = axi2arb_wframe_data; ewr = 1; m_run = 0;
      end else begin
        et = 2'b00; ed = axi2arb_rframe_data; err = 1;
        if (!axi2arb_wframe_valid)   m_run = 0;
        else if (m_run < RUN_MAX)    m_run = m_run + 1;
      end
      rd = int'($urandom_range(3, 0));
      dd = int'($urandom_range(3, 0));
      run_grant(rd, dd, ($urandom_range(3, 0) == 0), g);
      n_tests++;
      if (g.typ !== et || g.data !== ed || g.rr !== err || g.wr !== ewr ||
          g.acks != int'(et == 2'b10) || g.busy != rd + dd + 2 || g.stable !== 1) begin
        n_fail++;
        $display("FAIL random[%0d]: got type=%b rr=%b wr=%b acks=%0d busy=%0d data=%h expected type=%b rr=%b wr=%b busy=%0d data=%h",
                 it, g.typ, g.rr, g.wr, g.acks, g.busy, g.data, et, err, ewr, rd + dd + 2, ed);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lone_read();
    test_starvation();
    test_refresh();
    test_backpressure();
    test_stray_done();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
